event_fifo_reader: RTL

Read-side counterpart of the acquisition core's FIFO write port. It drains 64-bit sample words from the standard (non-FWFT) event FIFO and serialises each word into two 32-bit AXI4-Stream beats, low half first. It marks the last beat of every event with `m_tlast`. It sits in the f125 domain between the event FIFO and the readout DMA/stream consumer.

---
 rtl/daq_pkg.sv | 16 +
 rtl/event_fifo_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/daq_pkg.sv
// Shared types and widths for the f125-domain acquisition readout path.
package daq_pkg;

    localparam int EVT_CNT_W = 16;
    localparam int FIFO_DW   = 64;
    localparam int STREAM_DW = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_HI = 3'd4
    } reader_state_t;

endpackage

// File: rtl/event_fifo_reader.sv
// Drains 64-bit words from a standard (non-FWFT) event FIFO and emits each
// word as two 32-bit AXI4-Stream beats, low half first, with tlast per event.
module event_fifo_reader
    import daq_pkg::*;
#(
    parameter int WORDS_PER_EVENT = 8
) (
    input  logic        f125_clk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic [63:0] dout_i,
    input  logic        empty_i,
    output logic        rd_en_o,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy_o,
    output logic [15:0] event_count_o
);

    localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_EVENT - 1);

    reader_state_t          state_q, state_d;
    logic [FIFO_DW-1:0]     hold_q, hold_d;
    logic [7:0]             word_cnt_q, word_cnt_d;
    logic [EVT_CNT_W-1:0]   event_cnt_q, event_cnt_d;
    logic                   rd_en_q, rd_en_d;
    logic [STREAM_DW-1:0]   tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        word_cnt_d  = word_cnt_q;
        event_cnt_d = event_cnt_q;
        rd_en_d     = 1'b0;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && !empty_i) begin
                    rd_en_d    = 1'b1;
                    word_cnt_d = 8'd0;
                    state_d    = ST_READ;
                end
            end
            // The registered strobe is high while in READ; the FIFO returns
            // data the following cycle, which WAIT captures.
            ST_READ: begin
                if (rd_en_q) begin
                    state_d = ST_WAIT;
                end else if (!empty_i) begin
                    rd_en_d = 1'b1;
                end
            end
            ST_WAIT: begin
                hold_d   = dout_i;
                tdata_d  = dout_i[STREAM_DW-1:0];
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
                state_d  = ST_SEND_LO;
            end
            ST_SEND_LO: begin
                if (m_tready) begin
                    tdata_d = hold_q[FIFO_DW-1:STREAM_DW];
                    tlast_d = (word_cnt_q == LAST_WORD);
                    state_d = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (m_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        event_cnt_d = event_cnt_q + 16'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        // Issue the next read straight away to keep 4 cycles/word.
                        word_cnt_d = word_cnt_q + 8'd1;
                        rd_en_d    = !empty_i;
                        state_d    = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge f125_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            word_cnt_q  <= '0;
            event_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            word_cnt_q  <= word_cnt_d;
            event_cnt_q <= event_cnt_d;
            rd_en_q     <= rd_en_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_en_o       = rd_en_q;
    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign m_tlast       = tlast_q;
    assign busy_o        = busy_q;
    assign event_count_o = event_cnt_q;

endmodule
